// File: rtl/mem_port_arbiter.sv
// Shared Avalon-MM port controller: arbitrates instruction fetch vs load/store, returns aligned read data.
// Optional macro MEM_TIMEOUT_EN aborts a bus cycle after TIMEOUT_CYCLES consecutive waitrequest cycles.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [31:0]       fetch_rdata,
  output logic              fetch_done,
  input  logic              data_req,
  input  logic              data_we,
  input  logic              data_byte,
  input  logic              data_signed,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic [31:0]       data_rdata,
  output logic              data_done,
  output logic              bus_error,
  output logic              stall,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
);

  typedef enum logic [1:0] {IDLE, FETCH_BUS, DATA_BUS, RESP} state_t;

  state_t            state_q, state_d;
  logic              is_data_q, is_data_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic              byte_q, byte_d;
  logic              sgn_q, sgn_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              in_bus;
  logic              data_misal;
  logic              fetch_misal;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  // Timeout support compiled out; the parameter stays so both builds share one interface.
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

  function automatic logic [31:0] load_result(input logic [31:0] word, input logic [1:0] lane,
                                              input logic is_byte, input logic sgn);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    if (!is_byte) return word;
    return {{24{sgn & b[7]}}, b};
  endfunction

  assign data_misal  = ~data_byte & (data_addr[1:0] != 2'b00);
  assign fetch_misal = (fetch_addr[1:0] != 2'b00);

  always_comb begin
    state_d   = state_q;
    is_data_d = is_data_q;
    err_d     = err_q;
    addr_d    = addr_q;
    we_d      = we_q;
    byte_d    = byte_q;
    sgn_d     = sgn_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef MEM_TIMEOUT_EN
        cnt_d = '0;
`endif
        // Load/store first: the instruction already in EXEC must retire before the next fetch.
        if (data_req) begin
          is_data_d = 1'b1;
          addr_d    = data_addr;
          we_d      = data_we;
          byte_d    = data_byte;
          sgn_d     = data_signed;
          wdata_d   = data_wdata;
          rdata_d   = '0;
          err_d     = data_misal;
          state_d   = data_misal ? RESP : DATA_BUS;
        end else if (fetch_req) begin
          is_data_d = 1'b0;
          addr_d    = fetch_addr;
          we_d      = 1'b0;
          byte_d    = 1'b0;
          sgn_d     = 1'b0;
          wdata_d   = '0;
          rdata_d   = '0;
          err_d     = fetch_misal;
          state_d   = fetch_misal ? RESP : FETCH_BUS;
        end
      end
      FETCH_BUS, DATA_BUS: begin
        if (!avm_waitrequest) begin
          rdata_d = avm_readdata;
          state_d = RESP;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      is_data_q <= 1'b0;
      err_q     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      is_data_q <= is_data_d;
      err_q     <= err_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  // Request payload and captured read word; every consumer is gated by state.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    we_q    <= we_d;
    byte_q  <= byte_d;
    sgn_q   <= sgn_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
  end

  assign in_bus         = (state_q == FETCH_BUS) || (state_q == DATA_BUS);
  assign avm_read       = (state_q == FETCH_BUS) || ((state_q == DATA_BUS) && !we_q);
  assign avm_write      = (state_q == DATA_BUS) && we_q;
  assign avm_address    = in_bus ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign avm_byteenable = !in_bus ? 4'b0000 : (byte_q ? (4'b0001 << addr_q[1:0]) : 4'b1111);
  assign avm_writedata  = !in_bus ? 32'd0 : (byte_q ? {4{wdata_q[7:0]}} : wdata_q);

  assign fetch_done  = (state_q == RESP) && !is_data_q;
  assign data_done   = (state_q == RESP) && is_data_q;
  assign bus_error   = (state_q == RESP) && err_q;
  assign fetch_rdata = fetch_done ? rdata_q : 32'd0;
  assign data_rdata  = (data_done && !we_q) ? load_result(rdata_q, addr_q[1:0], byte_q, sgn_q) : 32'd0;
  assign stall       = (fetch_req | data_req) & ~(fetch_done | data_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model with randomized requesters plus directed cases.
module tb_mem_port_arbiter;
  localparam int AW = 32;
`ifdef MEM_TIMEOUT_EN
  localparam int TO = 5;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = '0;
  logic        data_req = 1'b0, data_we = 1'b0, data_byte = 1'b0, data_signed = 1'b0;
  logic [31:0] data_addr = '0, data_wdata = '0;
  logic [31:0] avm_readdata = '0;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] fetch_rdata, data_rdata, avm_address, avm_writedata;
  logic        fetch_done, data_done, bus_error, stall, avm_read, avm_write;
  logic [3:0]  avm_byteenable;

  mem_port_arbiter #(.ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_rdata(fetch_rdata), .fetch_done(fetch_done),
    .data_req(data_req), .data_we(data_we), .data_byte(data_byte), .data_signed(data_signed),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata), .data_done(data_done),
    .bus_error(bus_error), .stall(stall),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;

  // Model: one transaction record with accept cycle and release cycle.
  bit          m_act = 1'b0, m_data, m_we, m_byte, m_sgn, m_err;
  logic [31:0] m_addr, m_wdata, m_rd;
  int          m_acc, m_rel = -1, m_wcnt;
  bit          c_bus, c_done;
  bit          f_busy = 1'b0, d_busy = 1'b0, f_cool = 1'b0, d_cool = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_load(input logic [31:0] rd, input logic [31:0] a,
                                           input bit isb, input bit sg);
    logic [31:0] v;
    if (!isb) return rd;
    v = (rd >> (8 * a[1:0])) & 32'hFF;
    if (sg && v[7]) v = v | 32'hFFFF_FF00;
    return v;
  endfunction

  task automatic check_cycle();
    bit          wr_acc;
    logic [31:0] exp_rd;
    c_bus  = m_act && (m_rel < 0);
    c_done = m_act && (m_rel >= 0) && (cyc == m_rel + 1);
    wr_acc = m_data && m_we;
    exp_rd = (m_err || wr_acc) ? 32'd0 : (m_data ? exp_load(m_rd, m_addr, m_byte, m_sgn) : m_rd);
    chk("avm_read", 32'(avm_read), 32'(c_bus && !wr_acc));
    chk("avm_write", 32'(avm_write), 32'(c_bus && wr_acc));
    if (c_bus) begin
      chk("avm_address", avm_address, {m_addr[31:2], 2'b00});
      chk("avm_byteenable", 32'(avm_byteenable), m_byte ? (32'd1 << m_addr[1:0]) : 32'hF);
      if (wr_acc) chk("avm_writedata", avm_writedata, m_byte ? {4{m_wdata[7:0]}} : m_wdata);
    end
    chk("fetch_done", 32'(fetch_done), 32'(c_done && !m_data));
    chk("data_done", 32'(data_done), 32'(c_done && m_data));
    chk("bus_error", 32'(bus_error), 32'(c_done && m_err));
    if (c_done && !m_data) chk("fetch_rdata", fetch_rdata, exp_rd);
    if (c_done && m_data) chk("data_rdata", data_rdata, exp_rd);
    chk("stall", 32'(stall), 32'((fetch_req || data_req) && !c_done));
    f_cool = 1'b0;
    d_cool = 1'b0;
    if (c_done) begin
      if (m_data) begin data_req = 1'b0; d_busy = 1'b0; d_cool = 1'b1; end
      else begin fetch_req = 1'b0; f_busy = 1'b0; f_cool = 1'b1; end
    end
  endtask

  // Applies the inputs the DUT samples at the coming rising edge.
  task automatic model_update();
    if (c_bus) begin
      if (!avm_waitrequest) begin
        m_rel = cyc;
        m_rd  = avm_readdata;
      end else begin
`ifdef MEM_TIMEOUT_EN
        m_wcnt++;
        if (m_wcnt == TO) begin m_rel = cyc; m_err = 1'b1; end
`endif
      end
    end
    if (c_done) m_act = 1'b0;
    else if (!m_act && (data_req || fetch_req)) begin
      m_act = 1'b1; m_acc = cyc; m_rel = -1; m_wcnt = 0; m_rd = '0;
      m_data = data_req;
      if (data_req) begin
        m_addr = data_addr; m_we = data_we; m_byte = data_byte; m_sgn = data_signed;
        m_wdata = data_wdata; m_err = !data_byte && (data_addr[1:0] != 2'b00);
      end else begin
        m_addr = fetch_addr; m_we = 1'b0; m_byte = 1'b0; m_sgn = 1'b0;
        m_wdata = '0; m_err = (fetch_addr[1:0] != 2'b00);
      end
      if (m_err) m_rel = cyc;
    end
    cyc++;
  endtask

  task automatic rand_stim();
    avm_waitrequest = ($urandom_range(0, 2) == 0);
    avm_readdata    = $urandom;
    if (!f_busy && !f_cool && $urandom_range(0, 3) == 0) begin
      fetch_req = 1'b1; f_busy = 1'b1;
      fetch_addr = $urandom;
      if ($urandom_range(0, 7) != 0) fetch_addr[1:0] = 2'b00;
    end else if (f_busy && m_act && !m_data) begin
      fetch_addr = $urandom;
      if ($urandom_range(0, 19) == 0) fetch_req = 1'b0;
    end
    if (!d_busy && !d_cool && $urandom_range(0, 4) == 0) begin
      data_req = 1'b1; d_busy = 1'b1;
      data_we = 1'($urandom); data_byte = 1'($urandom); data_signed = 1'($urandom);
      data_wdata = $urandom; data_addr = $urandom;
      if (!data_byte && $urandom_range(0, 7) != 0) data_addr[1:0] = 2'b00;
    end else if (d_busy && m_act && m_data) begin
      data_addr = $urandom; data_wdata = $urandom;
      data_we = 1'($urandom); data_byte = 1'($urandom); data_signed = 1'($urandom);
      if ($urandom_range(0, 19) == 0) data_req = 1'b0;
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    check_cycle();
  endtask

  task automatic set_data(input bit we, input bit bt, input bit sg, input logic [31:0] a,
                          input logic [31:0] wd);
    data_req = 1'b1; d_busy = 1'b1;
    data_we = we; data_byte = bt; data_signed = sg; data_addr = a; data_wdata = wd;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_avm_read", 32'(avm_read), 32'd0);
    chk("reset_avm_write", 32'(avm_write), 32'd0);
    chk("reset_avm_address", avm_address, 32'd0);
    chk("reset_byteenable", 32'(avm_byteenable), 32'd0);
    chk("reset_done", 32'({fetch_done, data_done, bus_error}), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    rst = 1'b0;
    nxt(); model_update();

    // Boot fetch: done on the third cycle with the returned word.
    nxt(); fetch_req = 1'b1; f_busy = 1'b1; fetch_addr = 32'hBFC0_0000;
    avm_waitrequest = 1'b0; avm_readdata = 32'h3C01_1234; model_update();
    nxt(); chk("boot_read", 32'(avm_read), 32'd1); chk("boot_addr", avm_address, 32'hBFC0_0000); model_update();
    nxt(); chk("boot_done", 32'(fetch_done), 32'd1); chk("boot_rdata", fetch_rdata, 32'h3C01_1234); model_update();
    nxt(); chk("boot_idle", 32'({avm_read, fetch_done}), 32'd0); model_update();

    // Byte loads from lane 3, signed then unsigned.
    for (int s = 1; s >= 0; s--) begin
      nxt(); set_data(1'b0, 1'b1, 1'(s), 32'h0000_1003, 32'd0); avm_readdata = 32'h80FF_FFFF; model_update();
      nxt(); chk("lb_byteenable", 32'(avm_byteenable), 32'h8); model_update();
      nxt(); chk("lb_rdata", data_rdata, s ? 32'hFFFF_FF80 : 32'h0000_0080); model_update();
      nxt(); model_update();
    end

    // Word store held off by four waitrequest cycles.
    nxt(); set_data(1'b1, 1'b0, 1'b0, 32'h0000_2000, 32'hDEAD_BEEF); model_update();
    for (int i = 0; i < 5; i++) begin
      nxt();
      chk("sw_write", 32'(avm_write), 32'd1);
      chk("sw_addr", avm_address, 32'h0000_2000);
      chk("sw_wdata", avm_writedata, 32'hDEAD_BEEF);
      chk("sw_stall", 32'(stall), 32'd1);
      avm_waitrequest = (i < 4);
      model_update();
    end
    nxt(); chk("sw_done", 32'(data_done), 32'd1); model_update();
    nxt(); model_update();

    // Simultaneous requests: data first, then fetch.
    nxt(); set_data(1'b0, 1'b0, 1'b0, 32'h0000_3000, 32'd0);
    fetch_req = 1'b1; f_busy = 1'b1; fetch_addr = 32'h0000_0400; avm_readdata = 32'h1234_5678; model_update();
    nxt(); chk("both_first_addr", avm_address, 32'h0000_3000); model_update();
    nxt(); chk("both_data_done", 32'({data_done, fetch_done}), 32'b10); model_update();
    nxt(); chk("both_gap_stall", 32'(stall), 32'd1); model_update();
    nxt(); chk("both_fetch_addr", avm_address, 32'h0000_0400); model_update();
    nxt(); chk("both_fetch_done", 32'({data_done, fetch_done}), 32'b01); model_update();
    nxt(); model_update();

    // Misaligned word load: no bus cycle, error with done.
    nxt(); set_data(1'b0, 1'b0, 1'b0, 32'h0000_1002, 32'd0); model_update();
    nxt();
    chk("mis_done_err", 32'({data_done, bus_error, avm_read}), 32'b110);
    chk("mis_rdata", data_rdata, 32'd0);
    model_update();
    nxt(); model_update();

`ifdef MEM_TIMEOUT_EN
    nxt(); set_data(1'b0, 1'b0, 1'b0, 32'h0000_0050, 32'd0); avm_waitrequest = 1'b1; model_update();
    for (int i = 0; i < TO; i++) begin
      nxt(); chk("to_read", 32'(avm_read), 32'd1); model_update();
    end
    nxt(); chk("to_error", 32'({data_done, bus_error}), 32'b11); chk("to_rdata", data_rdata, 32'd0); model_update();
    avm_waitrequest = 1'b0;
    nxt(); model_update();
`endif

    for (int n = 0; n < 3000; n++) begin
      nxt(); rand_stim(); model_update();
    end
    // Drain the outstanding requesters before the reset test.
    avm_waitrequest = 1'b0;
    for (int n = 0; n < 20; n++) begin
      nxt(); model_update();
    end

    // Reset in the middle of a stalled store.
    nxt(); set_data(1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h1234_5678); avm_waitrequest = 1'b1; model_update();
    nxt(); chk("rst_pre_write", 32'(avm_write), 32'd1); model_update();
    #2 rst = 1'b1;
    #1;
    chk("rst_bus_drop", 32'({avm_write, avm_read}), 32'd0);
    chk("rst_addr_drop", avm_address, 32'd0);
    data_req = 1'b0; d_busy = 1'b0; m_act = 1'b0; avm_waitrequest = 1'b0;
    @(negedge clk); rst = 1'b0;
    nxt(); fetch_req = 1'b1; f_busy = 1'b1; fetch_addr = 32'h0000_0100; avm_readdata = 32'hCAFE_0001; model_update();
    nxt(); chk("post_rst_read", 32'(avm_read), 32'd1); model_update();
    nxt(); chk("post_rst_rdata", fetch_rdata, 32'hCAFE_0001); model_update();
    nxt(); model_update();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
